embertrail_fetch: RTL and testbench
===================================

# embertrail_fetch

Instruction fetch unit for the Embertrail core. It prefetches 16-bit instruction halfwords from instruction memory into a small FIFO and assembles single (16-bit) or dual (32-bit) packets for the control unit, which consumes them as its IR/PC inputs. It accepts the control unit's next-PC at packet completion. A sequential next-PC pops the packet; any other value flushes the buffer and redirects fetch.

## Interface
- DEPTH, 4: halfword FIFO depth; also the cap on in-flight plus buffered halfwords (power of two, ≥2).
- iClock  in  1  single clock, rising edge.
- iResetN  in  1  asynchronous, active-low reset.
- iLoad  in  1  pulse: control unit finished the current packet; sample iNextPC.
- iNextPC  in  16  halfword address of the next packet.
- oIR  out  32  packet: [15:0] first halfword, [31:16] second halfword when dual, else 0.
- oPC  out  16  halfword address of oIR[15:0].
- oIRValid  out  1  oIR/oPC hold a complete packet.
- oMemReq  out  1  fetch request.
- oMemAddr  out  16  halfword address of the request.
- iMemGnt  in  1  request accepted this cycle.
- iMemValid  in  1  response valid; responses return in order, ≥1 cycle after grant.
- iMemData  in  16  response halfword.

## Operation
- Reset values: oIR=0, oPC=0, oIRValid=0, oMemReq=0, oMemAddr=0. Fetch pointer=0, FIFO empty, in-flight=0, drop=0, state FILL.
- Packet length: 2 halfwords if head halfword bit 15 = 1, else 1. oIRValid=1 iff the FIFO count is ≥ the length.
- oMemReq=1 in FILL when in-flight + count < DEPTH. On oMemReq & iMemGnt, in-flight++ and the fetch pointer++ (mod 2^16). oMemAddr = fetch pointer.
- If iMemValid and drop=0, push iMemData and in-flight--. If drop>0, discard the response, drop-- and in-flight--.
- Pop: iLoad & oIRValid & iNextPC == oPC + length (mod 2^16). Remove length halfwords; oPC advances by length.
- Redirect: iLoad under any other condition, including oIRValid=0. On redirect:
  - FIFO is emptied and oPC = iNextPC.
  - fetch pointer = iNextPC.
  - drop = in-flight after this cycle's grant and response are applied.
  - A grant in the redirect cycle counts as in-flight to drop. A response in the redirect cycle is discarded.
  - Next state: DRAIN if drop>0, else FILL.
- FSM:
  - FILL: issue requests.
  - DRAIN: no requests; go to FILL in the cycle after drop reaches 0.
  - A redirect while in DRAIN updates the pointer and drop and stays in DRAIN.
- Wrap-around: a dual packet at 0xFFFF takes its second halfword from 0x0000. Pointers are 16-bit modulo.
- Simultaneous pop and push in one cycle are both applied. The count never exceeds DEPTH, because requests are throttled.
- A response with in-flight=0 is an illegal stimulus; behaviour is undefined (flag with a bench assertion).
- Reset mid-operation: all state returns immediately (asynchronously) to reset values. Responses still in flight after reset release are illegal stimulus.

## Timing
- FIFO, oIR, oPC and oIRValid are registered; oMemReq/oMemAddr are decoded from registered state only.
- Response at edge T is visible on oIRValid after T (same cycle as the pushed data).
- Minimum redirect-to-valid latency, with no drop and a grant in the first request cycle:
  - iLoad sampled at edge T0.
  - Request with the new address in cycle T0..T1.
  - Response sampled at T2.
  - oIRValid after T2.
- Back-to-back single packets with a 1-cycle memory sustain one pop per cycle once the FIFO is primed.
- First request after reset release: oMemReq=1, oMemAddr=0 in the first cycle.

## Configuration
- FETCH_STALL_COUNT_EN defined: adds output oStallCount (16 bits).
  - Reset value 0.
  - Increments on every cycle with oIRValid=0 after reset release.
  - Saturates at 0xFFFF.
  - Cleared only by reset.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then memory returning its address as data (single packets, bit15=0), grant always, 1-cycle latency, iLoad each cycle with iNextPC=oPC+1 -> oPC sequence 0,1,2,3…; one pop per cycle after priming; first oIRValid 2 cycles after the first request.
- Halfword 0x0000=0x8005, 0x0001=0x1234 -> oIRValid only once both are present; oIR=0x12348005, oPC=0. iLoad iNextPC=2 -> pop; next oPC=2.
- Redirect with 3 in flight, 3-cycle latency, iLoad iNextPC=0x0040 -> three stale responses dropped; no oMemReq while in DRAIN; first new request at 0x0040; oIR from 0x0040.
- Dual packet at 0xFFFF (0x8001) with 0x0000=0x00AA -> oIR=0x00AA8001. Pop with iNextPC=0x0001 -> next oPC=0x0001.
- Grant withheld (iMemGnt=0) for 10 cycles -> oMemReq held at a stable address, oIRValid=0. With FETCH_STALL_COUNT_EN, oStallCount increments by 10 over this window.
- Assert iResetN low mid-DRAIN -> all outputs 0 immediately; after release, first request at address 0.

Source files
------------

// File: rtl/embertrail_fetch.sv
// embertrail_fetch: instruction prefetch buffer and packet assembler.
// Prefetches 16-bit halfwords into a DEPTH-entry FIFO and presents single or dual
// packets to the control unit. A sequential iNextPC pops the packet; any other
// load flushes the buffer and redirects fetch, dropping stale in-flight responses.
// Optional feature macro: FETCH_STALL_COUNT_EN adds the oStallCount output.
module embertrail_fetch #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        iClock,
    input  logic        iResetN,
    input  logic        iLoad,
    input  logic [15:0] iNextPC,
    output logic [31:0] oIR,
    output logic [15:0] oPC,
    output logic        oIRValid,
    output logic        oMemReq,
    output logic [15:0] oMemAddr,
    input  logic        iMemGnt,
    input  logic        iMemValid,
    input  logic [15:0] iMemData
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [15:0] oStallCount
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DepthLim = (CW + 1)'(DEPTH);

    localparam logic [0:0] StFill  = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    logic [15:0]   fifo_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
    logic [15:0]   fetch_q, fetch_d, pc_q, pc_d;
    logic [0:0]    state_q, state_d;

    logic [15:0]   head, second;
    logic          dual, ir_valid, grant, pop, redirect, push;
    logic [CW-1:0] len;

    // Packet decode and fetch request, all from registered state
    always_comb begin
        head     = fifo_q[rd_ptr_q];
        second   = fifo_q[rd_ptr_q + AW'(1)];
        dual     = head[15];
        len      = dual ? CW'(2) : CW'(1);
        ir_valid = (count_q >= len);
        oIRValid = ir_valid;
        oIR      = ir_valid ? {(dual ? second : 16'h0000), head} : 32'h0;
        oPC      = pc_q;
        // Gated by reset so the request reads 0 while reset is held
        oMemReq  = iResetN && (state_q == StFill) &&
                   (({1'b0, inflight_q} + {1'b0, count_q}) < DepthLim);
        oMemAddr = fetch_q;
        grant    = oMemReq & iMemGnt;
        pop      = iLoad & ir_valid & (iNextPC == (pc_q + 16'(len)));
        redirect = iLoad & ~pop;
        push     = iMemValid & (drop_q == '0) & ~redirect;
    end

    // Next-state: pop/push bookkeeping, redirect flush, drain control
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pc_d       = pc_q;
        fetch_d    = grant ? (fetch_q + 16'd1) : fetch_q;
        inflight_d = inflight_q + CW'(grant) - CW'(iMemValid);
        drop_d     = (iMemValid && drop_q != '0) ? (drop_q - CW'(1)) : drop_q;
        state_d    = state_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = iNextPC;
            fetch_d  = iNextPC;
            // Everything still outstanding, including this cycle's grant, is stale
            drop_d   = inflight_d;
            state_d  = (state_q == StDrain || inflight_d != '0) ? StDrain : StFill;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(len);
                pc_d     = pc_q + 16'(len);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            count_d = count_q - (pop ? len : '0) + (push ? CW'(1) : '0);
            // Leave DRAIN one cycle after the last stale response is gone
            if (state_q == StDrain && drop_q == '0) begin
                state_d = StFill;
            end
        end
    end

    // Control state registers
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            fetch_q    <= '0;
            pc_q       <= '0;
            state_q    <= StFill;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fetch_q    <= fetch_d;
            pc_q       <= pc_d;
            state_q    <= state_d;
        end
    end

    // Halfword storage, cleared so the head decode is defined from reset
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= iMemData;
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles without a complete packet
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            stall_q <= '0;
        end else if (!ir_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign oStallCount = stall_q;
`endif

endmodule

// File: tb/tb_embertrail_fetch.sv
// Bench for embertrail_fetch: directed scenarios plus randomized traffic, all
// compared every cycle against a queue-based model of the fetch buffer.
module tb_embertrail_fetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] next_pc;
    logic [31:0] ir;
    logic [15:0] pc;
    logic        ir_valid;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_valid;
    logic [15:0] mem_data;
`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    always #5 clk = ~clk;

    embertrail_fetch #(.DEPTH(DEPTH)) dut (
        .iClock    (clk),
        .iResetN   (rst_n),
        .iLoad     (load),
        .iNextPC   (next_pc),
        .oIR       (ir),
        .oPC       (pc),
        .oIRValid  (ir_valid),
        .oMemReq   (mem_req),
        .oMemAddr  (mem_addr),
        .iMemGnt   (mem_gnt),
        .iMemValid (mem_valid),
        .iMemData  (mem_data)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .oStallCount (stall_count)
`endif
    );

    logic [15:0] mem_img [65536];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Memory: granted addresses with the cycle their response may be driven
    logic [15:0] pend_addr [$];
    int          pend_due  [$];

    // Model: buffered halfwords, in-flight requests (1 = stale), pointers
    logic [15:0] m_buf [$];
    bit          m_inf [$];
    logic [15:0] m_pc, m_fptr;
    bit          m_drain;
    int          m_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_len();
        if (m_buf.size() == 0) return 1;
        return m_buf[0][15] ? 2 : 1;
    endfunction

    function automatic bit m_valid();
        return (m_buf.size() >= m_len());
    endfunction

    function automatic bit m_req();
        return !m_drain && ((m_inf.size() + m_buf.size()) < DEPTH);
    endfunction

    function automatic logic [15:0] good_npc();
        return 16'(m_pc + m_len());
    endfunction

    task automatic compare();
        check("valid", {31'h0, ir_valid}, {31'h0, m_valid()});
        check("pc", {16'h0, pc}, {16'h0, m_pc});
        if (m_valid()) begin
            check("ir", ir, {(m_len() == 2) ? m_buf[1] : 16'h0000, m_buf[0]});
        end
        check("req", {31'h0, mem_req}, {31'h0, m_req()});
        if (m_req()) begin
            check("addr", {16'h0, mem_addr}, {16'h0, m_fptr});
        end
`ifdef FETCH_STALL_COUNT_EN
        check("stall", {16'h0, stall_count}, 32'(m_stall));
`endif
    endtask

    task automatic model_update(input bit ld, input logic [15:0] npc, input bit gnt,
                                input bit mv, input logic [15:0] md);
        int  len    = m_len();
        bit  valid  = m_valid();
        bit  req    = m_req();
        int  stale0 = 0;
        bit  popit, redir, st;
        foreach (m_inf[i]) if (m_inf[i]) stale0++;
        popit = ld && valid && (npc == 16'(m_pc + len));
        redir = ld && !popit;
        if (!valid && m_stall < 65535) m_stall++;
        if (mv && m_inf.size() > 0) begin
            st = m_inf.pop_front();
            if (!st && !redir) m_buf.push_back(md);
        end
        if (req && gnt) begin
            m_inf.push_back(1'b0);
            m_fptr = m_fptr + 16'd1;
        end
        if (redir) begin
            m_buf.delete();
            m_pc   = npc;
            m_fptr = npc;
            foreach (m_inf[i]) m_inf[i] = 1'b1;
            m_drain = m_drain || (m_inf.size() > 0);
        end else begin
            if (popit) begin
                repeat (len) void'(m_buf.pop_front());
                m_pc = 16'(m_pc + len);
            end
            if (m_drain && stale0 == 0) m_drain = 1'b0;
        end
    endtask

    // One clock cycle: compare, drive inputs, advance memory and model
    task automatic step(input bit ld, input logic [15:0] npc, input bit gnt, input int lat);
        bit          mv = 1'b0;
        logic [15:0] md = 16'h0;
        compare();
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mv = 1'b1;
            md = mem_img[pend_addr.pop_front()];
            pend_due.delete(0);
        end
        assert (!mv || m_inf.size() > 0)
        else begin
            bad++;
            $display("FAIL resp_without_inflight: response driven with nothing in flight");
        end
        mem_valid = mv;
        mem_data  = md;
        mem_gnt   = gnt;
        load      = ld;
        next_pc   = npc;
        if (mem_req && gnt) begin
            pend_addr.push_back(mem_addr);
            pend_due.push_back(cyc + lat);
        end
        model_update(ld, npc, gnt, mv, md);
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        load      = 1'b0;
        next_pc   = 16'h0;
        mem_gnt   = 1'b0;
        mem_valid = 1'b0;
        mem_data  = 16'h0;
        pend_addr.delete();
        pend_due.delete();
        m_buf.delete();
        m_inf.delete();
        m_pc = 16'h0; m_fptr = 16'h0; m_drain = 1'b0; m_stall = 0;
        @(negedge clk);
        check("rst_ir", ir, 32'h0);
        check("rst_pc", {16'h0, pc}, 32'h0);
        check("rst_valid", {31'h0, ir_valid}, 32'h0);
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_addr", {16'h0, mem_addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ld;
        logic [15:0] npc;
        int r;

        // Sequential single packets, address as data
        for (int i = 0; i < 65536; i++) mem_img[i] = 16'(i) & 16'h7FFF;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                check("a_req0", {31'h0, mem_req}, 32'h1);
                check("a_addr0", {16'h0, mem_addr}, 32'h0);
            end
            if (k == 1) check("a_not_yet", {31'h0, ir_valid}, 32'h0);
            if (k == 2) check("a_first_valid", {31'h0, ir_valid}, 32'h1);
            if (k >= 2) check("a_pc_seq", {16'h0, pc}, 32'(k - 2));
            step(m_valid(), 16'(m_pc + 1), 1'b1, 1);
        end

        // Dual packet assembly and sequential pop
        mem_img[0] = 16'h8005; mem_img[1] = 16'h1234; mem_img[2] = 16'h0042;
        do_reset();
        step(1'b0, 16'h0, 1'b1, 1);
        step(1'b0, 16'h0, 1'b1, 1);
        check("b_wait_second", {31'h0, ir_valid}, 32'h0);
        step(1'b0, 16'h0, 1'b1, 1);
        check("b_valid", {31'h0, ir_valid}, 32'h1);
        check("b_ir", ir, 32'h12348005);
        check("b_pc", {16'h0, pc}, 32'h0);
        step(1'b1, 16'h0002, 1'b1, 1);
        check("b_pc_after", {16'h0, pc}, 32'h2);

        // Redirect with three in flight at latency 3
        mem_img[16'h0040] = 16'h0123;
        do_reset();
        step(1'b0, 16'h0, 1'b1, 3);
        step(1'b0, 16'h0, 1'b1, 3);
        step(1'b1, 16'h0040, 1'b1, 3);
        for (int k = 3; k < 7; k++) begin
            check("c_drain_noreq", {31'h0, mem_req}, 32'h0);
            step(1'b0, 16'h0, 1'b1, 3);
        end
        check("c_req_new", {31'h0, mem_req}, 32'h1);
        check("c_addr_new", {16'h0, mem_addr}, 32'h40);
        for (int k = 7; k < 11; k++) step(1'b0, 16'h0, 1'b1, 3);
        check("c_valid", {31'h0, ir_valid}, 32'h1);
        check("c_pc", {16'h0, pc}, 32'h40);
        check("c_ir", ir, 32'h00000123);

        // Asynchronous reset while draining
        do_reset();
        step(1'b0, 16'h0, 1'b1, 3);
        step(1'b0, 16'h0, 1'b1, 3);
        step(1'b1, 16'h0040, 1'b1, 3);
        step(1'b0, 16'h0, 1'b1, 3);
        rst_n = 1'b0;
        #1;
        check("f_pc_async", {16'h0, pc}, 32'h0);
        check("f_addr_async", {16'h0, mem_addr}, 32'h0);
        check("f_valid_async", {31'h0, ir_valid}, 32'h0);
        check("f_req_async", {31'h0, mem_req}, 32'h0);
        do_reset();
        check("f_req_after", {31'h0, mem_req}, 32'h1);
        check("f_addr_after", {16'h0, mem_addr}, 32'h0);

        // Dual packet wrapping from 0xFFFF to 0x0000
        mem_img[16'hFFFF] = 16'h8001; mem_img[0] = 16'h00AA; mem_img[1] = 16'h0005;
        do_reset();
        step(1'b1, 16'hFFFF, 1'b1, 1);
        for (int k = 0; k < 20 && !m_valid(); k++) step(1'b0, 16'h0, 1'b1, 1);
        check("d_valid", {31'h0, ir_valid}, 32'h1);
        check("d_pc", {16'h0, pc}, 32'hFFFF);
        check("d_ir", ir, 32'h00AA8001);
        step(1'b1, 16'h0001, 1'b1, 1);
        check("d_pc_after", {16'h0, pc}, 32'h1);

        // Grant withheld for ten cycles
        do_reset();
        for (int k = 0; k < 10; k++) begin
            check("e_req_held", {31'h0, mem_req}, 32'h1);
            check("e_addr_held", {16'h0, mem_addr}, 32'h0);
            check("e_not_valid", {31'h0, ir_valid}, 32'h0);
            step(1'b0, 16'h0, 1'b0, 1);
        end
`ifdef FETCH_STALL_COUNT_EN
        check("e_stall10", {16'h0, stall_count}, 32'd10);
`endif

        // Randomized traffic
        for (int i = 0; i < 65536; i++) mem_img[i] = 16'($urandom);
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            r   = int'($urandom_range(0, 99));
            ld  = 1'b0;
            npc = 16'h0;
            if (m_valid()) begin
                if (r < 75) begin
                    ld = 1'b1; npc = good_npc();
                end else if (r < 82) begin
                    ld = 1'b1; npc = 16'($urandom);
                end
            end else if (r < 3) begin
                ld = 1'b1; npc = 16'($urandom);
            end
            step(ld, npc, ($urandom_range(0, 3) != 0), int'($urandom_range(1, 4)));
        end
        compare();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
